// File: rtl/ldst_ctrl_p.sv
// Load/store sequencer between the register file and a handshaked memory.
// Owns MAR/MDR, bounds each memory request with a timeout, and reports busy/done/err.
//
// state  | meaning
// IDLE   | waiting for i_start; op/ri/rj latched on acceptance
// ADDR   | read rj, capture address into MAR
// DATA   | read ri, capture store data into MDR
// MEM    | memory request outstanding, timeout counter running
// WB     | write MDR to ri
// INC    | write MAR+1 to rj
// DONE   | one-cycle done pulse
// ERR    | one-cycle err pulse after timeout
module ldst_ctrl_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RIDX_W = 4,
    parameter int TMO_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [RIDX_W-1:0] i_ri,
    input  logic [RIDX_W-1:0] i_rj,
    output logic [RIDX_W-1:0] o_reg_raddr,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic [RIDX_W-1:0] o_reg_waddr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_rw,
    output logic              o_mem_en,
    input  logic              i_mfc,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM, S_WB, S_INC, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_op;
    logic [RIDX_W-1:0]   r_ri, r_rj;
    logic [ADDR_W-1:0]   r_mar, w_mar_nxt, w_inc;
    logic [DATA_W-1:0]   r_mdr, w_mdr_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt, w_tmo_inc;
    logic                w_store, w_pi;

    assign w_store   = r_op[0];
    assign w_pi      = r_op[1];
    assign w_tmo_inc = r_tmo + 1'b1;
    assign w_inc     = w_mar_nxt + 1'b1;

    always_comb begin
        w_next      = r_state;
        w_mar_nxt   = r_mar;
        w_mdr_nxt   = r_mdr;
        w_tmo_nxt   = r_tmo;
        o_reg_raddr = '0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_ADDR;
            S_ADDR: begin
                o_reg_raddr = r_rj;
                w_mar_nxt   = i_reg_rdata[ADDR_W-1:0];
                w_tmo_nxt   = '0;
                w_next      = w_store ? S_DATA : S_MEM;
            end
            S_DATA: begin
                o_reg_raddr = r_ri;
                w_mdr_nxt   = i_reg_rdata;
                w_next      = S_MEM;
            end
            S_MEM: begin
                // mfc wins over a timeout landing in the same cycle
                if (i_mfc) begin
                    w_tmo_nxt = '0;
                    if (!w_store) begin
                        w_mdr_nxt = i_mem_rdata;
                        w_next    = S_WB;
                    end else begin
                        w_next = w_pi ? S_INC : S_DONE;
                    end
                end else if (&w_tmo_inc) begin
                    w_tmo_nxt = '0;
                    w_next    = S_ERR;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            S_WB:   w_next = w_pi ? S_INC : S_DONE;
            S_INC:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            S_ERR:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_ri        <= '0;
            r_rj        <= '0;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_tmo       <= '0;
            o_reg_waddr <= '0;
            o_reg_wdata <= '0;
            o_reg_we    <= 1'b0;
            o_mem_rw    <= 1'b1;
            o_mem_en    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_mar   <= w_mar_nxt;
            r_mdr   <= w_mdr_nxt;
            r_tmo   <= w_tmo_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_op <= i_op;
                r_ri <= i_ri;
                r_rj <= i_rj;
            end
            // outputs are registered off the next state so they align with it
            o_mem_en    <= (w_next == S_MEM);
            o_mem_rw    <= !((w_next == S_MEM) && w_store);
            o_reg_we    <= (w_next == S_WB) || (w_next == S_INC);
            o_reg_waddr <= (w_next == S_INC) ? r_rj : ((w_next == S_WB) ? r_ri : '0);
            o_reg_wdata <= (w_next == S_INC) ? DATA_W'(w_inc) :
                           ((w_next == S_WB) ? w_mdr_nxt : '0);
            o_busy      <= (w_next != S_IDLE);
            o_done      <= (w_next == S_DONE);
            o_err       <= (w_next == S_ERR);
        end
    end

    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;

endmodule

// File: tb/tb_ldst_ctrl_p.sv
// Scoreboard bench for ldst_ctrl_p: stimulus queues expected memory requests,
// register writes and done/err pulses; a negedge monitor pops and compares.
module tb_ldst_ctrl_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [3:0]  ri = '0, rj = '0;
    logic [3:0]  reg_raddr, reg_waddr;
    logic [15:0] reg_rdata, reg_wdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        reg_we, mem_rw, mem_en, busy, done, err;
    logic        mfc = 1'b0;

    logic [15:0] rf [16];
    logic [15:0] mem [logic [15:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int wait_tgt = 0;
    int wcnt = 0;
    logic prev_en = 1'b0;

    localparam int K_MEM = 0, K_WE = 1, K_DONE = 2, K_ERR = 3;
    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        logic        rw;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ldst_ctrl_p dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_ri(ri), .i_rj(rj), .o_reg_raddr(reg_raddr), .i_reg_rdata(reg_rdata),
        .o_reg_waddr(reg_waddr), .o_reg_wdata(reg_wdata), .o_reg_we(reg_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_mem_rw(mem_rw), .o_mem_en(mem_en), .i_mfc(mfc),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    assign reg_rdata = rf[reg_raddr];

    // register file writes and memory responder, both away from the active edge
    always @(negedge clk) begin
        if (reg_we) rf[reg_waddr] = reg_wdata;
        if (mem_en) begin
            if (wcnt == wait_tgt) begin
                mfc = 1'b1;
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0000;
                if (!mem_rw) mem[mem_addr] = mem_wdata;
            end else begin
                mfc = 1'b0;
                wcnt++;
            end
        end else begin
            mfc = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [15:0] a, input logic [15:0] d,
                          input logic rw);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got event kind %0d a=%0h d=%0h, expected none",
                     kind, a, d);
            return;
        end
        e = sb_q.pop_front();
        if (e.kind != kind ||
            (kind == K_MEM && (a !== e.a || rw !== e.rw || (!e.rw && d !== e.d))) ||
            (kind == K_WE && (a !== e.a || d !== e.d))) begin
            n_bad++;
            $display("FAIL sb_event: got kind %0d a=%0h d=%0h rw=%0b expected kind %0d a=%0h d=%0h rw=%0b",
                     kind, a, d, rw, e.kind, e.a, e.d, e.rw);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en && !prev_en) sb_pop(K_MEM, mem_addr, mem_wdata, mem_rw);
        if (reg_we) sb_pop(K_WE, {12'h000, reg_waddr}, reg_wdata, 1'b0);
        if (done)   sb_pop(K_DONE, 16'h0, 16'h0, 1'b0);
        if (err)    sb_pop(K_ERR, 16'h0, 16'h0, 1'b0);
        prev_en = mem_en;
    end

    task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input logic rw);
        exp_t e;
        e.kind = kind; e.a = a; e.d = d; e.rw = rw;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [3:0] i_ri,
                          input logic [3:0] i_rj, input int wt, input int exp_lat,
                          input int exp_en);
        int n, busy_c, en_c;
        bit got;
        wait_tgt = wt;
        tick();
        start = 1'b1; op = o; ri = i_ri; rj = i_rj;
        tick();
        start = 1'b0;
        n = 1; busy_c = 0; en_c = 0; got = 0;
        while (n <= 200 && !got) begin
            if (busy) busy_c++;
            if (mem_en) en_c++;
            if (done || err) got = 1;
            else begin
                tick();
                n++;
            end
        end
        chk({nm, "_finished"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_busy_cycles"}, 32'(busy_c), 32'(exp_lat));
        chk({nm, "_mem_en_cycles"}, 32'(en_c), 32'(exp_en));
        tick();
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        chk({nm, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16; k++) rf[k] = 16'h0000;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_rw", 32'(mem_rw), 32'd1);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;

        rf[2] = 16'h0040; mem[16'h0040] = 16'hBEEF;
        push(K_MEM, 16'h0040, 16'h0, 1'b1);
        push(K_WE, 16'h0005, 16'hBEEF, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("load", 2'd0, 4'd5, 4'd2, 0, 4, 1);
        chk("load_r5", 32'(rf[5]), 32'h0000BEEF);

        rf[1] = 16'h1234; rf[3] = 16'hFFFF;
        push(K_MEM, 16'hFFFF, 16'h1234, 1'b0);
        push(K_WE, 16'h0003, 16'h0000, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("store_pi", 2'd3, 4'd1, 4'd3, 3, 8, 4);
        chk("store_pi_mem", 32'(mem[16'hFFFF]), 32'h00001234);
        chk("store_pi_r3_wrap", 32'(rf[3]), 32'h00000000);

        rf[6] = 16'h00A5; rf[7] = 16'h0200;
        push(K_MEM, 16'h0200, 16'h00A5, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("store", 2'd1, 4'd6, 4'd7, 1, 5, 2);
        chk("store_mem", 32'(mem[16'h0200]), 32'h000000A5);

        rf[8] = 16'h0300; rf[9] = 16'h7777;
        push(K_MEM, 16'h0300, 16'h0, 1'b1);
        push(K_ERR, 16'h0, 16'h0, 1'b0);
        run_op("timeout", 2'd0, 4'd9, 4'd8, 1000, 17, 15);
        chk("timeout_r9_kept", 32'(rf[9]), 32'h00007777);

        mem[16'h0300] = 16'h5A5A;
        push(K_MEM, 16'h0300, 16'h0, 1'b1);
        push(K_WE, 16'h0009, 16'h5A5A, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("mfc_at_limit", 2'd0, 4'd9, 4'd8, 14, 18, 15);
        chk("mfc_at_limit_r9", 32'(rf[9]), 32'h00005A5A);

        rf[4] = 16'h0010; mem[16'h0010] = 16'h0AAA;
        push(K_MEM, 16'h0010, 16'h0, 1'b1);
        push(K_WE, 16'h0004, 16'h0AAA, 1'b0);
        push(K_WE, 16'h0004, 16'h0011, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("load_pi_same", 2'd2, 4'd4, 4'd4, 0, 5, 1);
        chk("load_pi_r4", 32'(rf[4]), 32'h00000011);

        // reset in the middle of an outstanding load
        rf[10] = 16'h1111;
        wait_tgt = 1000;
        push(K_MEM, 16'h0040, 16'h0, 1'b1);
        tick();
        start = 1'b1; op = 2'd0; ri = 4'd10; rj = 4'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_in_mem", 32'(mem_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_rw", 32'(mem_rw), 32'd1);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        repeat (3) tick();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_r10_kept", 32'(rf[10]), 32'h00001111);
        chk("abort_sb_drained", 32'(sb_q.size()), 32'd0);
        push(K_MEM, 16'h0040, 16'h0, 1'b1);
        push(K_WE, 16'h000A, 16'hBEEF, 1'b0);
        push(K_DONE, 16'h0, 16'h0, 1'b0);
        run_op("after_reset", 2'd0, 4'd10, 4'd2, 0, 4, 1);
        chk("after_reset_r10", 32'(rf[10]), 32'h0000BEEF);

        // start held across done: re-accepted after one idle cycle
        wait_tgt = 0;
        for (int k = 0; k < 2; k++) begin
            push(K_MEM, 16'h0040, 16'h0, 1'b1);
            push(K_WE, 16'h000B, 16'hBEEF, 1'b0);
            push(K_DONE, 16'h0, 16'h0, 1'b0);
        end
        tick();
        start = 1'b1; op = 2'd0; ri = 4'd11; rj = 4'd2;
        tick();
        repeat (3) tick();
        chk("b2b_done1", 32'(done), 32'd1);
        tick();
        chk("b2b_idle_gap", 32'(busy), 32'd0);
        tick();
        chk("b2b_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (3) tick();
        chk("b2b_done2", 32'(done), 32'd1);
        tick();
        chk("b2b_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("b2b_r11", 32'(rf[11]), 32'h0000BEEF);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldst_ctrl_p.md
Name: ldst_ctrl_p

Overview:
- Parametrised successor to the single-width load/store sequencer.
- Executes LOAD, STORE, LOAD-post-increment and STORE-post-increment between a register file and a handshaked memory (MFC), and owns the MAR/MDR holding registers internally.
- Adds an MFC timeout with an error flag, a busy/done handshake to the instruction-fetch sequencer, and configurable data, address and register-index widths.
- Sits between the instruction decoder and the memory/register-file datapath.

Parameters:
DATA_W, 16, data/register width
ADDR_W, 16, memory address width (address taken from low ADDR_W bits of rj)
RIDX_W, 4, register index width (2**RIDX_W registers)
TMO_W, 4, MFC timeout counter width; timeout after 2**TMO_W-1 wait cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  0=LOAD, 1=STORE, 2=LOAD_PI, 3=STORE_PI
ri  in  RIDX_W  data register index
rj  in  RIDX_W  address register index
reg_raddr  out  RIDX_W  register file read index (combinational read)
reg_rdata  in  DATA_W  register file read data, valid same cycle
reg_waddr  out  RIDX_W  register write index
reg_wdata  out  DATA_W  register write data
reg_we  out  1  register write strobe, one cycle
mem_addr  out  ADDR_W  MAR contents
mem_wdata  out  DATA_W  MDR contents (store)
mem_rdata  in  DATA_W  memory read data, valid when mfc=1
mem_rw  out  1  1=read, 0=write
mem_en  out  1  memory request, held until mfc or timeout
mfc  in  1  memory function complete
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion (IF trigger)
err  out  1  one-cycle pulse on timeout; replaces done

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0 (mem_rw=1), MAR/MDR/op/ri/rj latches and timeout counter cleared. Reset mid-operation aborts immediately, no register write occurs afterwards.
- All outputs registered except reg_raddr (decoded from state).
- States: IDLE, ADDR, DATA, MEM, WB, INC, DONE, ERR.
- IDLE: start=1 latches op, ri, rj -> ADDR. start in any other state ignored.
- ADDR: reg_raddr=rj; MAR<=reg_rdata[ADDR_W-1:0]; -> DATA if store op, else MEM.
- DATA: reg_raddr=ri; MDR<=reg_rdata; -> MEM.
- MEM: mem_en=1, mem_rw=1 for loads/0 for stores; the timeout counter increments each cycle mfc=0.
  - mfc=1 -> mem_en drops next cycle. For a load, MDR<=mem_rdata. Next state is WB for a load, INC for STORE_PI, DONE for STORE.
  - mfc=1 has priority over a timeout reached in the same cycle.
  - Counter reaching all-ones with mfc=0 -> ERR; no register write is performed.
- WB: reg_waddr=ri, reg_wdata=MDR, reg_we=1 for one cycle; -> INC if LOAD_PI, else DONE.
- INC: reg_waddr=rj, reg_wdata=MAR+1, zero-extended to DATA_W, with wrap modulo 2**ADDR_W; reg_we=1; -> DONE.
- ri==rj with LOAD_PI: INC write is last, so rj ends with MAR+1.
- DONE: done=1 one cycle; -> IDLE. ERR: err=1 one cycle; -> IDLE.
- Latency from start to done, with mfc on the first MEM cycle:
  - LOAD 4 cycles (ADDR, MEM, WB, DONE)
  - STORE 4 cycles (ADDR, DATA, MEM, DONE)
  - LOAD_PI 5 cycles
  - STORE_PI 5 cycles
  - Each extra MFC wait cycle adds 1.
- start held high across done: the op is re-accepted on the IDLE cycle following DONE (back-to-back, one idle cycle).

Test Plan:
- LOAD: R2=0x0040, mem[0x40]=0xBEEF, op=0 ri=5 rj=2, mfc on first MEM cycle -> mem_addr=0x0040, mem_rw=1, R5=0xBEEF, done 4 cycles after start, busy high for 4 cycles.
- STORE_PI: R1=0x1234, R3=0xFFFF, op=3 ri=1 rj=3, mfc after 3 waits -> mem_wdata=0x1234 at 0xFFFF, mem_rw=0, R3 wraps to 0x0000, done at cycle 8.
- Timeout: op=0, mfc never asserted -> mem_en high for 15 cycles, err pulse, done never asserted, reg_we never asserted, R[ri] unchanged.
- mfc asserted on the same cycle the counter saturates -> completes normally with done, no err.
- Reset asserted during MEM of a LOAD -> outputs clear asynchronously, reg_we never fires, start after deassert executes normally.
- LOAD_PI with ri=rj=4, R4=0x0010, mem[0x10]=0x0AAA -> WB writes 0x0AAA, then INC writes 0x0011; final R4=0x0011.
